// File: rtl/memreq_queue.sv
// memreq_queue: load/store request FIFO between the CPU issue logic and a
// single-outstanding memory unit. Requests are released one at a time as a
// one-cycle strobe while the memory unit is idle. A bus error halts issue
// until a synchronous clear flushes the queue.
// Optional feature macro: MEMQ_BYPASS_EN. When defined, a push into an empty,
// idle queue goes straight to the strobe without being written to the FIFO.
module memreq_queue #(
  parameter int LGDEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_stb,
  input  logic               i_op,
  input  logic [31:0]        i_addr,
  input  logic [31:0]        i_data,
  input  logic [4:0]         i_oreg,
  output logic               o_stall,
  output logic               o_mem_stb,
  output logic               o_mem_op,
  output logic [31:0]        o_mem_addr,
  output logic [31:0]        o_mem_data,
  output logic [4:0]         o_mem_oreg,
  input  logic               i_mem_busy,
  input  logic               i_mem_err,
  output logic               o_err,
  output logic [LGDEPTH:0]   o_fill,
  output logic               o_pending
);

  localparam int DEPTH = 1 << LGDEPTH;
  localparam logic [LGDEPTH:0] FILL_FULL = (LGDEPTH + 1)'(DEPTH);

  // Entry layout: {op, addr, data, oreg}
  logic [69:0]          fifo_mem [DEPTH];
  logic [69:0]          push_word;
  logic [69:0]          head_word;

  logic [LGDEPTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LGDEPTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LGDEPTH:0]     fill_q, fill_d;
  logic                 err_q, err_d;
  logic                 mem_stb_q, mem_stb_d;
  logic [69:0]          mem_req_q, mem_req_d;

  logic                 accept;
  logic                 bypass;
  logic                 push_fifo;
  logic                 issue;

  assign push_word = {i_op, i_addr, i_data, i_oreg};
  assign head_word = fifo_mem[rd_ptr_q];

  // Stall depends only on registered state so the CPU never sees a loop through i_stb.
  assign o_stall = (fill_q == FILL_FULL) || err_q;
  assign accept  = i_stb && !o_stall && !i_clear;
  assign issue   = (fill_q != '0) && !mem_stb_q && !i_mem_busy && !err_q && !i_clear;

`ifdef MEMQ_BYPASS_EN
  assign bypass = accept && (fill_q == '0) && !i_mem_busy && !mem_stb_q && !err_q;
`else
  assign bypass = 1'b0;
`endif

  assign push_fifo = accept && !bypass;

  // Next-state: clear overrides everything; otherwise push, pop/issue and error capture.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    err_d     = err_q;
    mem_stb_d = 1'b0;
    mem_req_d = mem_req_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      err_d    = 1'b0;
    end else begin
      if (push_fifo) begin
        wr_ptr_d = wr_ptr_q + LGDEPTH'(1);
      end
      if (issue) begin
        rd_ptr_d  = rd_ptr_q + LGDEPTH'(1);
        mem_stb_d = 1'b1;
        mem_req_d = head_word;
      end else if (bypass) begin
        mem_stb_d = 1'b1;
        mem_req_d = push_word;
      end
      if (push_fifo && !issue) begin
        fill_d = fill_q + (LGDEPTH + 1)'(1);
      end else if (!push_fifo && issue) begin
        fill_d = fill_q - (LGDEPTH + 1)'(1);
      end
      if (i_mem_err) begin
        err_d = 1'b1;
      end
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      err_q     <= 1'b0;
      mem_stb_q <= 1'b0;
      mem_req_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      err_q     <= err_d;
      mem_stb_q <= mem_stb_d;
      mem_req_q <= mem_req_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge i_clk) begin
    if (push_fifo) begin
      fifo_mem[wr_ptr_q] <= push_word;
    end
  end

  assign o_mem_stb  = mem_stb_q;
  assign o_mem_op   = mem_req_q[69];
  assign o_mem_addr = mem_req_q[68:37];
  assign o_mem_data = mem_req_q[36:5];
  assign o_mem_oreg = mem_req_q[4:0];
  assign o_err      = err_q;
  assign o_fill     = fill_q;
  assign o_pending  = (fill_q != '0) || mem_stb_q || i_mem_busy;

endmodule

// File: tb/tb_memreq_queue.sv
// Self-checking bench for memreq_queue (LGDEPTH = 2). Expected requests go
// into a scoreboard queue when pushed and are compared against each strobe.
// A simple memory model raises busy for MEM_LAT cycles after every strobe.
module tb_memreq_queue;

  localparam int LGD     = 2;
  localparam int MEM_LAT = 3;

  typedef struct packed {
    logic        op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  oreg;
  } req_t;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          stb;
  logic          op;
  logic [31:0]   addr;
  logic [31:0]   data;
  logic [4:0]    oreg;
  logic          stall;
  logic          mem_stb;
  logic          mem_op;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_data;
  logic [4:0]    mem_oreg;
  logic          mem_busy;
  logic          mem_err;
  logic          err;
  logic [LGD:0]  fill;
  logic          pending;

  req_t sb[$];
  int   checks;
  int   errors;
  int   busy_cnt;
  logic busy_hold;
  logic busy_edge;
  logic stb_prev;

  memreq_queue #(.LGDEPTH(LGD)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clear    (clear),
    .i_stb      (stb),
    .i_op       (op),
    .i_addr     (addr),
    .i_data     (data),
    .i_oreg     (oreg),
    .o_stall    (stall),
    .o_mem_stb  (mem_stb),
    .o_mem_op   (mem_op),
    .o_mem_addr (mem_addr),
    .o_mem_data (mem_data),
    .o_mem_oreg (mem_oreg),
    .i_mem_busy (mem_busy),
    .i_mem_err  (mem_err),
    .o_err      (err),
    .o_fill     (fill),
    .o_pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_busy = (busy_cnt != 0) || busy_hold;

  // Busy as seen by the DUT at each rising edge.
  always @(posedge clk) busy_edge = mem_busy;

  // Strobe monitor, scoreboard check and memory busy model.
  always @(negedge clk) begin
    req_t exp_r;
    if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    if (rst_n && mem_stb) begin
      checks++;
      if (stb_prev) begin
        errors++;
        $display("FAIL stb_width: strobe high two cycles, addr=%h", mem_addr);
      end
      if (busy_edge) begin
        errors++;
        $display("FAIL stb_while_busy: strobe issued while busy, addr=%h", mem_addr);
      end
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_stb: got addr=%h oreg=%0d, expected none", mem_addr, mem_oreg);
      end else begin
        exp_r = sb.pop_front();
        if ({mem_op, mem_addr, mem_data, mem_oreg} !== exp_r) begin
          errors++;
          $display("FAIL stb_fields: got op=%b addr=%h data=%h oreg=%0d, expected op=%b addr=%h data=%h oreg=%0d",
                   mem_op, mem_addr, mem_data, mem_oreg, exp_r.op, exp_r.addr, exp_r.data, exp_r.oreg);
        end
      end
      busy_cnt = MEM_LAT;
    end
    stb_prev = rst_n && mem_stb;
  end

  // Called at a falling edge; drives one request across the next rising edge.
  task automatic push(input logic p_op, input logic [31:0] p_addr, input logic [31:0] p_data,
                      input logic [4:0] p_oreg, input bit exp_acc);
    req_t r;
    stb  = 1'b1;
    op   = p_op;
    addr = p_addr;
    data = p_data;
    oreg = p_oreg;
    checks++;
    if (stall !== !exp_acc) begin
      errors++;
      $display("FAIL stall_at_push: addr=%h stall=%b, expected %b", p_addr, stall, !exp_acc);
    end
    if (exp_acc) begin
      r = '{op: p_op, addr: p_addr, data: p_data, oreg: p_oreg};
      sb.push_back(r);
    end
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n = 0;
    while ((sb.size() != 0 || pending) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || pending) begin
      errors++;
      $display("FAIL %s_drain: %0d requests still expected, pending=%b, expected 0 after %0d cycles",
               name, sb.size(), pending, max_cyc);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp_v);
    end
  endtask

  task automatic test_reset();
    #1;
    chk("rst_fill", 32'(fill), 0);
    chk("rst_stb", 32'(mem_stb), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Mid-queue reset with fill = 3 and error set.
    busy_hold = 1'b1;
    push(1'b0, 32'h0000_0010, 32'h0, 5'd1, 1'b1);
    push(1'b1, 32'h0000_0014, 32'h1111, 5'd2, 1'b1);
    push(1'b0, 32'h0000_0018, 32'h0, 5'd3, 1'b1);
    chk("mid_fill3", 32'(fill), 3);
    mem_err = 1'b1;
    @(negedge clk);
    mem_err = 1'b0;
    chk("mid_err_set", 32'(err), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fill", 32'(fill), 0);
    chk("arst_stb", 32'(mem_stb), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_stall", 32'(stall), 0);
    chk("arst_pending", 32'(pending), 1);
    sb.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    busy_hold = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    push(1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 5'd5, 1'b1);
`ifdef MEMQ_BYPASS_EN
    chk("single_stb_n", 32'(mem_stb), 1);
    chk("single_fill_n", 32'(fill), 0);
    @(negedge clk);
    chk("single_stb_end", 32'(mem_stb), 0);
    chk("single_fill_end", 32'(fill), 0);
`else
    chk("single_stb_n", 32'(mem_stb), 0);
    chk("single_fill_n", 32'(fill), 1);
    @(negedge clk);
    chk("single_stb_n1", 32'(mem_stb), 1);
    chk("single_fill_n1", 32'(fill), 0);
    @(negedge clk);
    chk("single_stb_end", 32'(mem_stb), 0);
`endif
    wait_idle(20, "single");
  endtask

  task automatic test_fill();
    busy_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(i[0], 32'h0000_0100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 5'(i + 8), i < 4);
    end
    chk("full_fill", 32'(fill), 4);
    chk("full_stall", 32'(stall), 1);
    chk("full_nostb", 32'(mem_stb), 0);
    busy_hold = 1'b0;
    wait_idle(40, "fill");
    chk("fill_empty", 32'(fill), 0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      push(!i[0], 32'h0000_2000 + 32'(i * 8), 32'($urandom), 5'($urandom_range(0, 31)), 1'b1);
      repeat (2) @(negedge clk);
    end
    wait_idle(60, "wrap");
    chk("wrap_fill", 32'(fill), 0);
  endtask

  task automatic test_error();
    push(1'b0, 32'h0000_3000, 32'h0, 5'd1, 1'b1);
    push(1'b1, 32'h0000_3004, 32'h55, 5'd2, 1'b1);
    push(1'b0, 32'h0000_3008, 32'h0, 5'd3, 1'b1);
    mem_err = 1'b1;
    @(negedge clk);
    mem_err = 1'b0;
    chk("err_set", 32'(err), 1);
    chk("err_stall", 32'(stall), 1);
    chk("err_fill", 32'(fill), 2);
    // Queued work is now dead; any further strobe is unexpected.
    sb.delete();
    push(1'b0, 32'h0000_300C, 32'h0, 5'd4, 1'b0);
    repeat (6) @(negedge clk);
    chk("err_hold_fill", 32'(fill), 2);
    chk("err_hold", 32'(err), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_fill", 32'(fill), 0);
    chk("clr_err", 32'(err), 0);
    chk("clr_stall", 32'(stall), 0);
    push(1'b1, 32'h0000_3100, 32'h77, 5'd9, 1'b1);
    wait_idle(20, "after_clear");
  endtask

  task automatic test_simultaneous();
    req_t r;
    busy_hold = 1'b1;
    push(1'b0, 32'h0000_4000, 32'h0, 5'd1, 1'b1);
    push(1'b0, 32'h0000_4004, 32'h0, 5'd2, 1'b1);
    chk("sim_fill_pre", 32'(fill), 2);
    busy_hold = 1'b0;
    push(1'b1, 32'h0000_4008, 32'h99, 5'd3, 1'b1);
    chk("sim_fill_same", 32'(fill), 2);
    chk("sim_stb", 32'(mem_stb), 1);
    wait_idle(40, "sim");
    // Clear coinciding with a push and a would-be issue.
    busy_hold = 1'b1;
    push(1'b0, 32'h0000_4100, 32'h0, 5'd4, 1'b1);
    sb.delete();
    chk("clrpush_pre", 32'(fill), 1);
    busy_hold = 1'b0;
    clear = 1'b1;
    stb   = 1'b1;
    addr  = 32'h0000_4104;
    @(negedge clk);
    clear = 1'b0;
    stb   = 1'b0;
    chk("clrpush_fill", 32'(fill), 0);
    chk("clrpush_stb", 32'(mem_stb), 0);
    repeat (4) @(negedge clk);
    chk("clrpush_pending", 32'(pending), 0);
    chk("clrpush_fill_end", 32'(fill), 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    busy_cnt  = 0;
    busy_hold = 1'b0;
    busy_edge = 1'b0;
    stb_prev  = 1'b0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    stb       = 1'b0;
    op        = 1'b0;
    addr      = '0;
    data      = '0;
    oreg      = '0;
    mem_err   = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_error();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memreq_queue.md
# memreq_queue

Request queue between the CPU's memory-instruction issue logic and the single-outstanding memory unit. It accepts load/store requests from the CPU at one per clock and buffers them in a small FIFO. Each request is released to the memory unit as a one-cycle strobe once the unit is idle. On a bus error it halts and discards all queued work.

## Interface
- LGDEPTH, 2, log2 of FIFO depth (depth = 2**LGDEPTH); legal 1..5
- i_clk  in  1  clock; all state changes on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_clear  in  1  synchronous flush: empties FIFO, clears o_err
- i_stb  in  1  CPU request valid
- i_op  in  1  1 = store, 0 = load
- i_addr  in  32  byte-free word address
- i_data  in  32  store data
- i_oreg  in  5  load destination register
- o_stall  out  1  FIFO cannot accept (full or halted)
- o_mem_stb  out  1  one-cycle request strobe to memory unit
- o_mem_op / o_mem_addr / o_mem_data / o_mem_oreg  out  1/32/32/5  request fields, valid while o_mem_stb
- i_mem_busy  in  1  memory unit has an operation in flight
- i_mem_err  in  1  memory unit reports bus error (one-cycle pulse)
- o_err  out  1  sticky error flag
- o_fill  out  LGDEPTH+1  current number of queued entries
- o_pending  out  1  o_fill != 0 or o_mem_stb or i_mem_busy

## Operation
- Reset (i_rst_n low, asynchronous): read pointer, write pointer and o_fill = 0; o_mem_stb = 0; o_mem_* fields = 0; o_err = 0. o_stall = 0 and o_pending follows i_mem_busy.
- Pointers are LGDEPTH bits and wrap modulo depth. o_fill is LGDEPTH+1 bits, range 0..depth.
- Push: on i_stb && !o_stall, {op, addr, data, oreg} is written at the write pointer and the write pointer increments.
- i_stb while o_stall is a protocol violation. The request is dropped and no state changes.
- o_stall = (o_fill == depth) || o_err. This is combinational from registers, not from i_stb.
- Issue condition, evaluated each cycle: o_fill != 0 && !o_mem_stb && !i_mem_busy && !o_err && !i_clear.
- When the issue condition holds:
  - Next cycle, o_mem_stb = 1 and o_mem_* = head entry.
  - The read pointer increments (pop).
- Otherwise o_mem_stb = 0 next cycle. o_mem_* hold their last value.
- The memory unit raises busy the cycle after the strobe, so the !o_mem_stb term guarantees one request in flight.
- Simultaneous push and pop: o_fill unchanged, both pointers advance. A push is refused when full, even if a pop happens in the same cycle.
- Error: i_mem_err = 1 sets o_err on the next edge.
  - While o_err is set, no issue occurs and o_stall = 1.
  - Queued entries are retained until i_clear; o_fill is not forced to 0.
- i_clear (priority over push, pop and error): pointers and o_fill become 0, o_err becomes 0, o_mem_stb becomes 0.
  - An operation already in the memory unit completes unaffected.
  - An i_mem_err coinciding with i_clear is ignored.

## Timing
- Push to strobe, empty queue, memory idle: push at edge N, o_fill = 1 after N, o_mem_stb high in cycle N+1→N+2 (strobe visible after edge N+1).
- Back-to-back issue: the next strobe comes no earlier than the first cycle in which i_mem_busy is low after the previous strobe.
- o_fill reflects pushes and pops one cycle after the accepting or issuing edge.
- o_err rises one cycle after i_mem_err and falls one cycle after i_clear.

## Configuration
- MEMQ_BYPASS_EN defined:
  - Trigger: a push into an empty FIFO while !i_mem_busy, !o_mem_stb and !o_err.
  - Effect: the request drives o_mem_stb on the very next edge and is never written to the FIFO (o_fill stays 0).
  - Push-to-strobe latency becomes 1 cycle.
- MEMQ_BYPASS_EN undefined: every request passes through the FIFO, and minimum latency is 2 cycles as above.

## Test plan
- Reset: hold i_rst_n low mid-queue with o_fill = 3 → asynchronously o_fill = 0, o_mem_stb = 0, o_err = 0, o_stall = 0.
- Single load addr 0x00001000, oreg 5, idle memory → o_mem_stb pulse exactly one cycle with addr 0x00001000, oreg 5, op 0.
  - Bypass off: strobe 2 cycles after the push.
  - Bypass on: strobe 1 cycle after the push, o_fill stays 0.
- Fill, LGDEPTH = 2, i_mem_busy held high, push 5 requests → first 4 accepted, o_fill = 4, o_stall = 1, 5th dropped.
  - Release busy → 4 strobes in push order, each after busy drops, addresses intact.
- Wrap-around: 10 pushes interleaved with issues over a depth-4 FIFO → strobes in exact order, no loss or duplication, o_fill returns to 0.
- Error: 3 queued, i_mem_err pulse during the first op → o_err = 1 next cycle, no further strobes, o_stall = 1, o_fill = 2.
  - Then i_clear → o_fill = 0, o_err = 0, new push issues normally.
- Simultaneous: at o_fill = 2, push and issue in the same cycle → o_fill stays 2.
  - With i_clear asserted in the same cycle as a push → o_fill = 0, no strobe.
